// File: rtl/pic_frame_wr_ctrl_if.sv
// Byte-in / pixel-write bundle between the UART receiver, display timing and picture RAM.
interface pic_frame_wr_ctrl_if #(
    parameter int unsigned ADDR_W = 14
) ();
    logic [7:0]      rx_data;
    logic            rx_flag;
    logic            vs_pulse;
    logic            wr_en;
    logic [ADDR_W:0] wr_addr;
    logic [7:0]      wr_data;
    logic            rd_bank;
    logic            busy;
    logic            frame_done;
    logic            err_timeout;
    logic            overrun;

    // Upstream side: byte source and frame-start pulse, observes the write port.
    modport master (
        output rx_data, rx_flag, vs_pulse,
        input  wr_en, wr_addr, wr_data, rd_bank, busy, frame_done, err_timeout, overrun
    );

    // Sequencer side.
    modport slave (
        input  rx_data, rx_flag, vs_pulse,
        output wr_en, wr_addr, wr_data, rd_bank, busy, frame_done, err_timeout, overrun
    );
endinterface

// File: rtl/pic_frame_wr_ctrl.sv
// Write-side sequencer for the ping-pong picture RAM: hunts the 2-byte header,
// writes one full picture into the hidden bank, swaps banks on a display frame start.
module pic_frame_wr_ctrl #(
    parameter logic [13:0] PIC_SIZE = 14'd9604,
    parameter int unsigned ADDR_W   = 14,
    parameter logic [7:0]  HDR0     = 8'hAA,
    parameter logic [7:0]  HDR1     = 8'h55,
    parameter logic [23:0] TIMEOUT  = 24'd500000
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    pic_frame_wr_ctrl_if.slave bus
);
    localparam int unsigned        GAP_W    = 24;
    localparam logic [ADDR_W-1:0]  LAST_PIX = ADDR_W'(PIC_SIZE - 14'd1);
    localparam logic [GAP_W-1:0]   GAP_LAST = TIMEOUT - 24'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state, state_nx;
    logic [ADDR_W-1:0]  pix_cnt, pix_cnt_nx;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_nx;
    logic               wr_bank, wr_bank_nx;
    logic               rd_bank_q, rd_bank_nx;
    logic               wr_en_q, wr_en_nx;
    logic [ADDR_W:0]    wr_addr_q, wr_addr_nx;
    logic [7:0]         wr_data_q, wr_data_nx;
    logic               busy_q, busy_nx;
    logic               frame_done_q, frame_done_nx;
    logic               err_timeout_q, err_timeout_nx;
    logic               overrun_q, overrun_nx;
    logic               gap_hit;

    // A byte arriving in the would-be timeout cycle takes priority over the timeout.
    assign gap_hit = (gap_cnt == GAP_LAST);

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state, counters and next values of every registered output.
    always_comb begin
        state_nx       = state;
        pix_cnt_nx     = pix_cnt;
        gap_cnt_nx     = gap_cnt;
        wr_bank_nx     = wr_bank;
        rd_bank_nx     = rd_bank_q;
        wr_en_nx       = 1'b0;
        wr_addr_nx     = wr_addr_q;
        wr_data_nx     = wr_data_q;
        frame_done_nx  = 1'b0;
        err_timeout_nx = 1'b0;
        overrun_nx     = 1'b0;

        unique case (state)
            ST_IDLE: begin
                gap_cnt_nx = '0;
                if (bus.rx_flag && (bus.rx_data == HDR0)) begin
                    state_nx = ST_HDR;
                end
            end
            ST_HDR: begin
                if (bus.rx_flag) begin
                    gap_cnt_nx = '0;
                    if (bus.rx_data == HDR1) begin
                        state_nx   = ST_DATA;
                        pix_cnt_nx = '0;
                    end else if (bus.rx_data != HDR0) begin
                        state_nx = ST_IDLE;
                    end
                end else if (gap_hit) begin
                    state_nx       = ST_IDLE;
                    err_timeout_nx = 1'b1;
                end else begin
                    gap_cnt_nx = gap_cnt + 24'd1;
                end
            end
            ST_DATA: begin
                if (bus.rx_flag) begin
                    gap_cnt_nx = '0;
                    wr_en_nx   = 1'b1;
                    wr_addr_nx = {wr_bank, pix_cnt};
                    wr_data_nx = bus.rx_data;
                    if (pix_cnt == LAST_PIX) begin
                        state_nx      = ST_DONE;
                        frame_done_nx = 1'b1;
                    end else begin
                        pix_cnt_nx = pix_cnt + ADDR_W'(1);
                    end
                end else if (gap_hit) begin
                    state_nx       = ST_IDLE;
                    err_timeout_nx = 1'b1;
                end else begin
                    gap_cnt_nx = gap_cnt + 24'd1;
                end
            end
            ST_DONE: begin
                gap_cnt_nx = '0;
                if (bus.rx_flag) begin
                    overrun_nx = 1'b1;
                end
                if (bus.vs_pulse) begin
                    rd_bank_nx = wr_bank;
                    wr_bank_nx = ~wr_bank;
                    state_nx   = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        busy_nx = (state_nx != ST_IDLE);
    end

    // Counters, bank pointers and output registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pix_cnt       <= '0;
            gap_cnt       <= '0;
            wr_bank       <= 1'b1;
            rd_bank_q     <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            pix_cnt       <= pix_cnt_nx;
            gap_cnt       <= gap_cnt_nx;
            wr_bank       <= wr_bank_nx;
            rd_bank_q     <= rd_bank_nx;
            wr_en_q       <= wr_en_nx;
            wr_addr_q     <= wr_addr_nx;
            wr_data_q     <= wr_data_nx;
            busy_q        <= busy_nx;
            frame_done_q  <= frame_done_nx;
            err_timeout_q <= err_timeout_nx;
            overrun_q     <= overrun_nx;
        end
    end

    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.rd_bank     = rd_bank_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_pic_frame_wr_ctrl.sv
// Bench for pic_frame_wr_ctrl: byte-level stimulus against a transaction-level frame model.
module tb_pic_frame_wr_ctrl;
    localparam int unsigned ADDR_W = 14;
    localparam int          PIX    = 9604;
    localparam int          TO     = 200;
    localparam logic [7:0]  HDR0   = 8'hAA;
    localparam logic [7:0]  HDR1   = 8'h55;

    logic sys_clk;
    logic sys_rst_n;

    pic_frame_wr_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    pic_frame_wr_ctrl #(
        .PIC_SIZE (14'(PIX)),
        .ADDR_W   (ADDR_W),
        .HDR0     (HDR0),
        .HDR1     (HDR1),
        .TIMEOUT  (24'(TO))
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Observed side: write stream, pulse counts, rd_bank change legality.
    logic [22:0] obs_wr[$];
    int   obs_fd = 0, obs_to = 0, obs_ovr = 0, rd_bad = 0, last_to_cyc = -1;
    logic prev_rd = 1'b0, prev_vs = 1'b0;

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (bus.wr_en) obs_wr.push_back({bus.wr_addr, bus.wr_data});
            if (bus.frame_done) obs_fd <= obs_fd + 1;
            if (bus.err_timeout) begin
                obs_to      <= obs_to + 1;
                last_to_cyc <= cyc;
            end
            if (bus.overrun) obs_ovr <= obs_ovr + 1;
            if ((bus.rd_bank != prev_rd) && !prev_vs) rd_bad <= rd_bad + 1;
        end
        prev_rd <= bus.rd_bank;
        prev_vs <= bus.vs_pulse;
    end

    // Reference model: 0 hunting, 1 seen HDR0, 2 receiving pixels, 3 picture complete.
    int          m_mode = 0, m_pix = 0, m_last = 0;
    logic        m_wbank = 1'b1, m_rbank = 1'b0;
    logic [22:0] exp_wr[$];
    int          exp_fd = 0, exp_to = 0, exp_ovr = 0, exp_to_cyc = -1;
    int          obs_idx = 0, exp_idx = 0;

    task automatic model_timeout(input int now);
        if ((m_mode == 1 || m_mode == 2) && (now - m_last) > TO) begin
            m_mode     = 0;
            exp_to     = exp_to + 1;
            exp_to_cyc = m_last + TO + 1;
        end
    endtask

    task automatic model_byte(input logic [7:0] b, input int now);
        model_timeout(now);
        case (m_mode)
            0: if (b == HDR0) m_mode = 1;
            1: begin
                if (b == HDR1) begin
                    m_mode = 2;
                    m_pix  = 0;
                end else if (b != HDR0) begin
                    m_mode = 0;
                end
            end
            2: begin
                exp_wr.push_back({m_wbank, 14'(m_pix), b});
                m_pix = m_pix + 1;
                if (m_pix == PIX) begin
                    m_mode = 3;
                    exp_fd = exp_fd + 1;
                end
            end
            default: exp_ovr = exp_ovr + 1;
        endcase
        m_last = now;
    endtask

    task automatic model_vs(input int now);
        model_timeout(now);
        if (m_mode == 3) begin
            m_rbank = m_wbank;
            m_wbank = ~m_wbank;
            m_mode  = 0;
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_wbank = 1'b1;
        m_rbank = 1'b0;
    endtask

    // Stimulus primitives; inputs change 1 time unit after the active edge.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_byte(b, cyc);
        bus.rx_data = b;
        bus.rx_flag = 1'b1;
        tick();
        bus.rx_flag = 1'b0;
    endtask

    task automatic send_byte_vs(input logic [7:0] b);
        model_timeout(cyc);
        if (m_mode == 3) begin
            exp_ovr = exp_ovr + 1;
            model_vs(cyc);
        end else begin
            model_byte(b, cyc);
        end
        bus.rx_data  = b;
        bus.rx_flag  = 1'b1;
        bus.vs_pulse = 1'b1;
        tick();
        bus.rx_flag  = 1'b0;
        bus.vs_pulse = 1'b0;
    endtask

    task automatic pulse_vs();
        model_vs(cyc);
        bus.vs_pulse = 1'b1;
        tick();
        bus.vs_pulse = 1'b0;
    endtask

    task automatic send_pixels(input int n, input bit ramp);
        for (int i = 0; i < n; i++) begin
            send_byte(ramp ? 8'(i) : 8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 1)) tick();
        end
    endtask

    // Locates the first difference between the new observed and expected writes, then consumes both.
    task automatic wr_diff(output int idx, output logic [22:0] got, output logic [22:0] req,
                           output int ng, output int ne);
        ng  = obs_wr.size() - obs_idx;
        ne  = exp_wr.size() - exp_idx;
        idx = -1;
        got = '0;
        req = '0;
        for (int i = 0; i < ((ng > ne) ? ng : ne); i++) begin
            if (i >= ng || i >= ne || obs_wr[obs_idx + i] !== exp_wr[exp_idx + i]) begin
                idx = i;
                if (i < ng) got = obs_wr[obs_idx + i];
                if (i < ne) req = exp_wr[exp_idx + i];
                break;
            end
        end
        obs_idx = obs_wr.size();
        exp_idx = exp_wr.size();
    endtask

    int          d_idx, d_ng, d_ne;
    logic [22:0] d_got, d_req;

    task automatic test_reset();
        sys_rst_n    = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_flag  = 1'b0;
        bus.vs_pulse = 1'b0;
        repeat (3) tick();
        n_chk++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %b expected 0", bus.wr_en); end
        n_chk++; if (bus.wr_addr !== 15'd0) begin n_fail++; $display("FAIL rst_wr_addr: got %h expected 0", bus.wr_addr); end
        n_chk++; if (bus.wr_data !== 8'd0) begin n_fail++; $display("FAIL rst_wr_data: got %h expected 0", bus.wr_data); end
        n_chk++; if (bus.rd_bank !== 1'b0) begin n_fail++; $display("FAIL rst_rd_bank: got %b expected 0", bus.rd_bank); end
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
        n_chk++; if ({bus.frame_done, bus.err_timeout, bus.overrun} !== 3'b000) begin
            n_fail++; $display("FAIL rst_pulses: got %b expected 000", {bus.frame_done, bus.err_timeout, bus.overrun});
        end
        sys_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_full_frame();
        send_byte(HDR0);
        send_byte(HDR1);
        n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL t1_busy_hdr: got %b expected 1", bus.busy); end
        send_pixels(PIX, 1'b1);
        repeat (2) tick();
        wr_diff(d_idx, d_got, d_req, d_ng, d_ne);
        n_chk++; if (d_idx != -1) begin n_fail++; $display("FAIL t1_wr_stream: write %0d got %h expected %h (%0d writes seen, %0d required)", d_idx, d_got, d_req, d_ng, d_ne); end
        n_chk++; if (obs_fd != exp_fd) begin n_fail++; $display("FAIL t1_frame_done: got %0d pulses expected %0d", obs_fd, exp_fd); end
        n_chk++; if (bus.rd_bank !== m_rbank) begin n_fail++; $display("FAIL t1_rd_bank_before_vs: got %b expected %b", bus.rd_bank, m_rbank); end
        pulse_vs();
        n_chk++; if (bus.rd_bank !== m_rbank) begin n_fail++; $display("FAIL t1_rd_bank_swap: got %b expected %b", bus.rd_bank, m_rbank); end
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy_idle: got %b expected 0", bus.busy); end
    endtask

    task automatic test_header_hunt();
        logic [7:0] junk;
        for (int i = 0; i < 6; i++) begin
            junk = 8'($urandom_range(0, 255));
            if (junk == HDR0) junk = 8'h00;
            send_byte(junk);
        end
        send_byte(HDR0);
        send_byte(HDR0);
        send_byte(HDR1);
        send_pixels(3, 1'b0);
        tick();
        wr_diff(d_idx, d_got, d_req, d_ng, d_ne);
        n_chk++; if (d_idx != -1) begin n_fail++; $display("FAIL t2_wr_hdr_repeat: write %0d got %h expected %h (%0d writes seen, %0d required)", d_idx, d_got, d_req, d_ng, d_ne); end
        repeat (TO + 3) tick();
        model_timeout(cyc);
        send_byte(HDR0);
        send_byte(8'h12);
        repeat (3) tick();
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL t2_bad_hdr_busy: got %b expected 0", bus.busy); end
        wr_diff(d_idx, d_got, d_req, d_ng, d_ne);
        n_chk++; if (d_idx != -1) begin n_fail++; $display("FAIL t2_bad_hdr_writes: write %0d got %h expected %h (%0d writes seen, %0d required)", d_idx, d_got, d_req, d_ng, d_ne); end
    endtask

    task automatic test_timeout();
        logic rd_before;
        rd_before = bus.rd_bank;
        send_byte(HDR0);
        send_byte(HDR1);
        send_pixels(100, 1'b0);
        repeat (TO + 5) tick();
        model_timeout(cyc);
        n_chk++; if (obs_to != exp_to) begin n_fail++; $display("FAIL t3_timeout_count: got %0d expected %0d", obs_to, exp_to); end
        n_chk++; if (last_to_cyc != exp_to_cyc) begin n_fail++; $display("FAIL t3_timeout_cycle: got %0d expected %0d", last_to_cyc, exp_to_cyc); end
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL t3_busy: got %b expected 0", bus.busy); end
        n_chk++; if (bus.rd_bank !== rd_before) begin n_fail++; $display("FAIL t3_rd_bank: got %b expected %b", bus.rd_bank, rd_before); end
        // A byte landing exactly in the timeout cycle keeps the frame alive.
        send_byte(HDR0);
        send_byte(HDR1);
        send_byte(8'($urandom_range(0, 255)));
        repeat (TO - 1) tick();
        send_byte(8'($urandom_range(0, 255)));
        repeat (2) tick();
        n_chk++; if (obs_to != exp_to) begin n_fail++; $display("FAIL t3_edge_no_timeout: got %0d expected %0d", obs_to, exp_to); end
        wr_diff(d_idx, d_got, d_req, d_ng, d_ne);
        n_chk++; if (d_idx != -1) begin n_fail++; $display("FAIL t3_wr_same_bank: write %0d got %h expected %h (%0d writes seen, %0d required)", d_idx, d_got, d_req, d_ng, d_ne); end
        repeat (TO + 5) tick();
        model_timeout(cyc);
        n_chk++; if (obs_to != exp_to) begin n_fail++; $display("FAIL t3_second_timeout: got %0d expected %0d", obs_to, exp_to); end
    endtask

    task automatic test_overrun();
        send_byte(HDR0);
        send_byte(HDR1);
        send_pixels(PIX, 1'b0);
        repeat (2) tick();
        for (int i = 0; i < 5; i++) begin
            send_byte(8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (2) tick();
        n_chk++; if (obs_ovr != exp_ovr) begin n_fail++; $display("FAIL t4_overrun: got %0d expected %0d", obs_ovr, exp_ovr); end
        wr_diff(d_idx, d_got, d_req, d_ng, d_ne);
        n_chk++; if (d_idx != -1) begin n_fail++; $display("FAIL t4_wr_stream: write %0d got %h expected %h (%0d writes seen, %0d required)", d_idx, d_got, d_req, d_ng, d_ne); end
        n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL t4_busy_done: got %b expected 1", bus.busy); end
        pulse_vs();
        n_chk++; if (bus.rd_bank !== m_rbank) begin n_fail++; $display("FAIL t4_rd_bank_swap: got %b expected %b", bus.rd_bank, m_rbank); end
    endtask

    task automatic test_vs_coincide();
        logic rd_before;
        rd_before = bus.rd_bank;
        send_byte(HDR0);
        send_byte(HDR1);
        send_pixels(PIX - 1, 1'b0);
        send_byte_vs(8'($urandom_range(0, 255)));
        repeat (2) tick();
        n_chk++; if (bus.rd_bank !== rd_before) begin n_fail++; $display("FAIL t5_no_swap: got %b expected %b", bus.rd_bank, rd_before); end
        n_chk++; if (obs_fd != exp_fd) begin n_fail++; $display("FAIL t5_frame_done: got %0d expected %0d", obs_fd, exp_fd); end
        n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL t5_busy_done: got %b expected 1", bus.busy); end
        wr_diff(d_idx, d_got, d_req, d_ng, d_ne);
        n_chk++; if (d_idx != -1) begin n_fail++; $display("FAIL t5_wr_stream: write %0d got %h expected %h (%0d writes seen, %0d required)", d_idx, d_got, d_req, d_ng, d_ne); end
        pulse_vs();
        n_chk++; if (bus.rd_bank !== m_rbank) begin n_fail++; $display("FAIL t5_swap_next_vs: got %b expected %b", bus.rd_bank, m_rbank); end
    endtask

    task automatic test_reset_mid_frame();
        send_byte(HDR0);
        send_byte(HDR1);
        send_pixels(20, 1'b0);
        tick();
        wr_diff(d_idx, d_got, d_req, d_ng, d_ne);
        n_chk++; if (d_idx != -1) begin n_fail++; $display("FAIL t6_wr_pre_reset: write %0d got %h expected %h (%0d writes seen, %0d required)", d_idx, d_got, d_req, d_ng, d_ne); end
        // Strobe one more pixel and pull reset while its write is on the port.
        bus.rx_data = 8'h5A;
        bus.rx_flag = 1'b1;
        @(posedge sys_clk);
        #2;
        bus.rx_flag = 1'b0;
        n_chk++; if (bus.wr_en !== 1'b1) begin n_fail++; $display("FAIL t6_wr_en_before_reset: got %b expected 1", bus.wr_en); end
        sys_rst_n = 1'b0;
        #1;
        n_chk++; if ({bus.wr_en, bus.busy, bus.rd_bank} !== 3'b000) begin
            n_fail++; $display("FAIL t6_async_ctrl: got wr_en/busy/rd_bank=%b expected 000", {bus.wr_en, bus.busy, bus.rd_bank});
        end
        n_chk++; if ({bus.wr_addr, bus.wr_data} !== 23'd0) begin
            n_fail++; $display("FAIL t6_async_bus: got addr %h data %h expected 0 0", bus.wr_addr, bus.wr_data);
        end
        model_reset();
        obs_idx = obs_wr.size();
        exp_idx = exp_wr.size();
        tick();
        sys_rst_n = 1'b1;
        tick();
        send_byte(HDR0);
        send_byte(HDR1);
        send_pixels(3, 1'b0);
        repeat (2) tick();
        wr_diff(d_idx, d_got, d_req, d_ng, d_ne);
        n_chk++; if (d_idx != -1) begin n_fail++; $display("FAIL t6_wr_bank1_after_reset: write %0d got %h expected %h (%0d writes seen, %0d required)", d_idx, d_got, d_req, d_ng, d_ne); end
    endtask

    task automatic test_rd_bank_rule();
        n_chk++; if (rd_bad != 0) begin n_fail++; $display("FAIL rd_bank_off_vs: got %0d changes outside vs_pulse expected 0", rd_bad); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_header_hunt();
        test_timeout();
        test_overrun();
        test_vs_coincide();
        test_reset_mid_frame();
        test_rd_bank_rule();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
